// File: rtl/card_game_pkg.sv
// +----------------------------------------------------------------------------+
// | card_game_pkg : shared defaults, datapath state encoding, LFSR seed/taps   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package card_game_pkg;

   localparam int CARD_W_DEFAULT  = 3;
   localparam int SCORE_W_DEFAULT = 8;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_DRAW    = 3'd1;
   localparam logic [2:0] ST_DISPLAY = 3'd2;
   localparam logic [2:0] ST_RESPOND = 3'd3;
   localparam logic [2:0] ST_HANDOFF = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE    = ST_IDLE,
      S_DRAW    = ST_DRAW,
      S_DISPLAY = ST_DISPLAY,
      S_RESPOND = ST_RESPOND,
      S_HANDOFF = ST_HANDOFF
   } dp_state_t;

   localparam logic [7:0] LFSR_SEED = 8'hA5;
   // Feedback taps at bit positions 8,6,5,4 (1-based)
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
      return {cur[6:0], ^(cur & LFSR_TAPS)};
   endfunction

endpackage

`default_nettype wire

// File: rtl/card_datapath_if.sv
// +----------------------------------------------------------------------------+
// | card_datapath_if : control/player <-> card datapath signal bundle          |
// | Optional macro CARD_DATAPATH_HIGH_SCORE_EN adds high_score. Rev 1.0        |
// +----------------------------------------------------------------------------+
`default_nettype none

interface card_datapath_if
   import card_game_pkg::*;
#(
   parameter int CARD_W  = CARD_W_DEFAULT,
   parameter int SCORE_W = SCORE_W_DEFAULT
);
   logic                show_card;
   logic                load_answer;
   logic                analyse;
   logic                key_match;
   logic                key_nomatch;
   logic                next_card;
   logic                game_over;
   logic [CARD_W-1:0]   card_id;
   logic                card_valid;
   logic                correct_answer;
   logic [SCORE_W-1:0]  score;

`ifdef CARD_DATAPATH_HIGH_SCORE_EN
   logic [SCORE_W-1:0]  high_score;

   modport master (
      output show_card, load_answer, analyse, key_match, key_nomatch,
      input  next_card, game_over, card_id, card_valid, correct_answer, score, high_score
   );
   modport slave (
      input  show_card, load_answer, analyse, key_match, key_nomatch,
      output next_card, game_over, card_id, card_valid, correct_answer, score, high_score
   );
`else
   modport master (
      output show_card, load_answer, analyse, key_match, key_nomatch,
      input  next_card, game_over, card_id, card_valid, correct_answer, score
   );
   modport slave (
      input  show_card, load_answer, analyse, key_match, key_nomatch,
      output next_card, game_over, card_id, card_valid, correct_answer, score
   );
`endif

endinterface

`default_nettype wire

// File: rtl/card_lfsr.sv
// +----------------------------------------------------------------------------+
// | card_lfsr : 8-bit free-running Fibonacci LFSR, sync reset to seed          |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module card_lfsr
   import card_game_pkg::*;
(
   input  logic       clk,
   input  logic       resetn,
   output logic [7:0] lfsr_o
);

   logic [7:0] lfsr_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_next(lfsr_q);
      end
   end

   assign lfsr_o = lfsr_q;

endmodule

`default_nettype wire

// File: rtl/card_datapath.sv
// +----------------------------------------------------------------------------+
// | card_datapath : card draw/display, answer capture, score for 1-back game   |
// | Optional macro CARD_DATAPATH_HIGH_SCORE_EN adds high_score. Rev 1.0        |
// +----------------------------------------------------------------------------+
`default_nettype none

module card_datapath
   import card_game_pkg::*;
#(
   parameter int CARD_W         = CARD_W_DEFAULT,
   parameter int SCORE_W        = SCORE_W_DEFAULT,
   parameter int DISPLAY_CYCLES = 25000000,
   parameter int TIMEOUT_CYCLES = 150000000
)(
   input  logic            clk,
   input  logic            resetn,
   card_datapath_if.slave  dp
);

   localparam int DISP_W = $clog2(DISPLAY_CYCLES) + 1;
   localparam int TMO_W  = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [DISP_W-1:0] DISP_LAST = DISP_W'(DISPLAY_CYCLES - 1);
   localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [7:0]          lfsr;
   logic                lfsr_unused;
   logic [CARD_W-1:0]   card_d;
   logic                wrong_d;
   logic                score_inc;
   logic [SCORE_W-1:0]  score_d;

   dp_state_t           state_q;
   logic                phase_q;
   logic [DISP_W-1:0]   disp_cnt_q;
   logic [TMO_W-1:0]    tmo_cnt_q;
   logic                wrong_q;
   logic                next_card_q;
   logic                game_over_q;
   logic [CARD_W-1:0]   card_id_q;
   logic                card_valid_q;
   logic                correct_q;
   logic [SCORE_W-1:0]  score_q;
`ifdef CARD_DATAPATH_HIGH_SCORE_EN
   logic [SCORE_W-1:0]  high_q;
`endif

   card_lfsr u_lfsr (
      .clk    (clk),
      .resetn (resetn),
      .lfsr_o (lfsr)
   );

   // lfsr[7] set means "repeat the current card", which keeps matches frequent
   assign card_d      = lfsr[7] ? card_id_q : lfsr[CARD_W-1:0];
   assign lfsr_unused = ^lfsr[6:CARD_W];
   assign wrong_d     = (dp.key_match & dp.key_nomatch) | (dp.key_match != correct_q);
   assign score_inc   = dp.analyse & ~game_over_q & ~(&score_q);
   assign score_d     = score_q + SCORE_W'(1);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         phase_q      <= 1'b0;
         disp_cnt_q   <= '0;
         tmo_cnt_q    <= '0;
         wrong_q      <= 1'b0;
         next_card_q  <= 1'b0;
         game_over_q  <= 1'b0;
         card_id_q    <= '0;
         card_valid_q <= 1'b0;
         correct_q    <= 1'b0;
         score_q      <= '0;
`ifdef CARD_DATAPATH_HIGH_SCORE_EN
         high_q       <= '0;
`endif
      end else begin
         next_card_q <= 1'b0;
         if (score_inc) begin
            score_q <= score_d;
`ifdef CARD_DATAPATH_HIGH_SCORE_EN
            if (score_d > high_q) begin
               high_q <= score_d;
            end
`endif
         end

         case (state_q)
            S_IDLE: begin
               card_valid_q <= 1'b0;
               if (dp.show_card) begin
                  phase_q <= dp.load_answer;
                  state_q <= S_DRAW;
               end
            end
            S_DRAW: begin
               if (!dp.show_card) begin
                  state_q <= S_IDLE;
               end else begin
                  correct_q    <= (card_d == card_id_q);
                  card_id_q    <= card_d;
                  card_valid_q <= 1'b1;
                  disp_cnt_q   <= '0;
                  state_q      <= S_DISPLAY;
                  // A first-card draw starts a new game; overrides any increment
                  if (!phase_q) begin
                     game_over_q <= 1'b0;
                     score_q     <= '0;
                  end
               end
            end
            S_DISPLAY: begin
               if (!dp.show_card) begin
                  state_q <= S_IDLE;
               end else if (disp_cnt_q == DISP_LAST) begin
                  if (phase_q) begin
                     tmo_cnt_q <= '0;
                     state_q   <= S_RESPOND;
                  end else begin
                     state_q   <= S_HANDOFF;
                  end
               end else begin
                  disp_cnt_q <= disp_cnt_q + DISP_W'(1);
               end
            end
            S_RESPOND: begin
               if (!dp.show_card) begin
                  state_q <= S_IDLE;
               end else if (dp.key_match | dp.key_nomatch) begin
                  wrong_q <= wrong_d;
                  state_q <= S_HANDOFF;
               end else if (tmo_cnt_q == TMO_LAST) begin
                  wrong_q <= 1'b1;
                  state_q <= S_HANDOFF;
               end else begin
                  tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
               end
            end
            S_HANDOFF: begin
               next_card_q <= 1'b1;
               if (phase_q) begin
                  game_over_q <= wrong_q;
               end
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign dp.next_card      = next_card_q;
   assign dp.game_over      = game_over_q;
   assign dp.card_id        = card_id_q;
   assign dp.card_valid     = card_valid_q;
   assign dp.correct_answer = correct_q;
   assign dp.score          = score_q;
`ifdef CARD_DATAPATH_HIGH_SCORE_EN
   assign dp.high_score     = high_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_card_datapath.sv
// +----------------------------------------------------------------------------+
// | tb_card_datapath : randomized self-checking bench for card_datapath        |
// | Honours CARD_DATAPATH_HIGH_SCORE_EN when defined. Rev 1.0                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_card_datapath;

   localparam int CW = 3;
   localparam int SW = 8;
   localparam int DC = 4;
   localparam int TC = 10;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   card_datapath_if #(.CARD_W(CW), .SCORE_W(SW)) dp_if ();

   card_datapath #(
      .CARD_W         (CW),
      .SCORE_W        (SW),
      .DISPLAY_CYCLES (DC),
      .TIMEOUT_CYCLES (TC)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .dp     (dp_if)
   );

   // Reference: LFSR x^8+x^6+x^5+x^4+1 shifted toward the MSB, plus game state
   logic [7:0]    m_lfsr;
   logic [CW-1:0] m_card;
   bit            m_correct;
   bit            m_go;
   int            m_score;
   int            m_high;
   int            total = 0;
   int            bad   = 0;

   always @(posedge clk) begin
      if (!resetn) m_lfsr <= 8'hA5;
      else         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_cleared(input string tag);
      check({tag, "_next_card"},  dp_if.next_card,      0);
      check({tag, "_game_over"},  dp_if.game_over,      0);
      check({tag, "_card_id"},    dp_if.card_id,        0);
      check({tag, "_card_valid"}, dp_if.card_valid,     0);
      check({tag, "_correct"},    dp_if.correct_answer, 0);
      check({tag, "_score"},      dp_if.score,          0);
`ifdef CARD_DATAPATH_HIGH_SCORE_EN
      check({tag, "_high"},       dp_if.high_score,     0);
`endif
   endtask

   // Predicts the card drawn at the edge after the current one
   task automatic model_draw(input bit ph);
      logic [7:0] lf;
      lf = m_lfsr;
      if (lf[7]) m_correct = 1'b1;
      else begin
         m_correct = (lf[CW-1:0] == m_card);
         m_card    = lf[CW-1:0];
      end
      if (!ph) begin
         m_go    = 1'b0;
         m_score = 0;
      end
   endtask

   // mode: 0 right key, 1 wrong key, 2 both keys, 3 no key (timeout)
   task automatic run_phase(input bit ph, input int mode, input bit chain);
      int n, k, exp_n;
      bit stray;
      k     = $urandom_range(0, TC - 1);
      stray = ($urandom_range(0, 1) == 1);
      exp_n = !ph ? DC + 2 : (mode == 3 ? DC + 2 + TC : DC + 3 + k);
      dp_if.show_card   = 1'b1;
      dp_if.load_answer = ph;
      tick();
      check("next_card_single", dp_if.next_card, 0);
      model_draw(ph);
      tick();
      check("card_id",    dp_if.card_id,        m_card);
      check("card_valid", dp_if.card_valid,     1);
      check("correct",    dp_if.correct_answer, m_correct);
      check("draw_go",    dp_if.game_over,      m_go);
      check("draw_score", dp_if.score,          m_score);
      n = 1;
      while (n < 40 && !dp_if.next_card) begin
         dp_if.key_match   = 1'b0;
         dp_if.key_nomatch = 1'b0;
         if (stray && n == 2) dp_if.key_match = 1'b1;
         if (ph && mode != 3 && n == DC + 1 + k) begin
            case (mode)
               0:       begin dp_if.key_match = m_correct;  dp_if.key_nomatch = !m_correct; end
               1:       begin dp_if.key_match = !m_correct; dp_if.key_nomatch = m_correct;  end
               default: begin dp_if.key_match = 1'b1;       dp_if.key_nomatch = 1'b1;       end
            endcase
         end
         tick();
         n++;
      end
      dp_if.key_match   = 1'b0;
      dp_if.key_nomatch = 1'b0;
      check("next_card_latency", n, exp_n);
      if (ph) m_go = (mode != 0);
      check("game_over", dp_if.game_over, m_go);
      dp_if.show_card   = chain;
      dp_if.load_answer = chain;
   endtask

   task automatic analyse_cycle();
      dp_if.analyse = 1'b1;
      tick();
      dp_if.analyse = 1'b0;
      if (!m_go && m_score < (1 << SW) - 1) begin
         m_score++;
         if (m_score > m_high) m_high = m_score;
      end
      check("score", dp_if.score, m_score);
      check("next_card_single", dp_if.next_card, 0);
`ifdef CARD_DATAPATH_HIGH_SCORE_EN
      check("high_score", dp_if.high_score, m_high);
`endif
   endtask

   task automatic play_game(input int n_ok, input int last_mode);
      run_phase(1'b0, 0, 1'b1);
      for (int i = 0; i < n_ok; i++) begin
         run_phase(1'b1, 0, 1'b0);
         analyse_cycle();
      end
      run_phase(1'b1, last_mode, 1'b0);
      analyse_cycle();
   endtask

   task automatic abort_phase(input bit ph);
      bit seen;
      seen = 1'b0;
      dp_if.show_card   = 1'b1;
      dp_if.load_answer = ph;
      tick();
      model_draw(ph);
      tick();
      check("abort_card_id", dp_if.card_id, m_card);
      tick();
      dp_if.show_card = 1'b0;
      repeat (8) begin
         tick();
         if (dp_if.next_card) seen = 1'b1;
      end
      check("abort_next_card", seen, 0);
      check("abort_card_valid", dp_if.card_valid, 0);
      check("abort_game_over", dp_if.game_over, m_go);
   endtask

   initial begin
      #500000;
      bad++;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      dp_if.show_card   = 1'b0;
      dp_if.load_answer = 1'b0;
      dp_if.analyse     = 1'b0;
      dp_if.key_match   = 1'b0;
      dp_if.key_nomatch = 1'b0;
      m_card = '0; m_correct = 1'b0; m_go = 1'b0; m_score = 0; m_high = 0;
      resetn = 1'b0;
      repeat (3) tick();
      resetn = 1'b1;
      check_cleared("reset");
      tick();
      check_cleared("idle");

      play_game(3, 1);
      play_game(5, 3);
      play_game(2, 2);
      abort_phase(1'b1);
      abort_phase(1'b0);
      play_game(260, 1);

      dp_if.show_card   = 1'b1;
      dp_if.load_answer = 1'b0;
      repeat (4) tick();
      resetn          = 1'b0;
      dp_if.show_card = 1'b0;
      tick();
      resetn = 1'b1;
      m_card = '0; m_correct = 1'b0; m_go = 1'b0; m_score = 0; m_high = 0;
      check_cleared("midreset");
      play_game(2, 0);
      play_game(1, 3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
